// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver FSM states, 8N1 frame constants and divider helpers shared by the uart_rx files.
// DIV is clocks per bit; HALF is the start-bit wait that centres every later sample mid-bit.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int uart_half(input int clk_hz, input int baud);
    return uart_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte valid/ready stream plus sticky error flags and their clear.
// master is the receiver side; slave is the consuming IO-page side.
interface uart_rx_if;

  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;
  logic       i_clr_err;

  modport master (
    output o_data, o_valid, o_frame_err, o_overrun,
    input  i_ready, i_clr_err
  );

  modport slave (
    input  o_data, o_valid, o_frame_err, o_overrun,
    output i_ready, i_clr_err
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: DEPTH-entry (power of two) sync FIFO, head read straight from the registered array, no added latency.
// Push while full is accepted only together with a pop in the same cycle; pop while empty is ignored.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  // Pointers wrap modulo DEPTH by plain overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver; byte valid 2+HALF+9*DIV clocks after the start edge is captured. UART_RX_FIFO_EN selects a FIFO_DEPTH FIFO, else a 1-byte holding register.
// A byte arriving at a full buffer with no pop that cycle is dropped and sets sticky o_overrun.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int clk_freq_hz = 10_000_000,
  parameter int baud_rate   = 1_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_uart_rx,
  uart_rx_if.master io_bus
);

  localparam int DIV   = uart_div(clk_freq_hz, baud_rate);
  localparam int HALF  = uart_half(clk_freq_hz, baud_rate);
  localparam int CNT_W = $clog2(DIV);

  if (DIV < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_rx: DIV must be >= 4 and FIFO_DEPTH a power of two >= 2");
  end

  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_rx_s;
  logic             w_tick;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic             w_full;
  logic [7:0]       w_data;

  assign w_rx_s = r_sync2;
  assign w_tick = (r_cnt == '0);
  assign w_push = (r_state == ST_STOP) && w_tick && w_rx_s;
  assign w_pop  = w_valid && io_bus.i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (io_bus.i_clr_err) begin
        r_frame_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= CNT_W'(HALF - 1);
          end
        end
        ST_START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (w_rx_s) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DATA;
            r_cnt   <= CNT_W'(DIV - 1);
            r_idx   <= '0;
          end
        end
        ST_DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_cnt   <= CNT_W'(DIV - 1);
            if (r_idx == 3'(DATA_BITS - 1)) begin
              r_state <= ST_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (w_rx_s) begin
            r_state <= ST_IDLE;
          end else begin
            // Written after the clear above so a same-cycle error wins.
            r_frame_err <= 1'b1;
            r_state     <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (w_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic w_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (w_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_valid = !w_empty;
`else
  logic       r_valid;
  logic [7:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_push && (!r_valid || w_pop)) begin
      r_valid <= 1'b1;
      r_data  <= r_shift;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign w_valid = r_valid;
  assign w_full  = r_valid;
  assign w_data  = r_data;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else begin
      if (io_bus.i_clr_err) begin
        r_overrun <= 1'b0;
      end
      if (w_push && w_full && !w_pop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign io_bus.o_data      = w_data;
  assign io_bus.o_valid     = w_valid;
  assign io_bus.o_frame_err = r_frame_err;
  assign io_bus.o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames at 10 clocks/bit against hand-computed bytes, flags and latency.
// Expectations for the overrun cases follow the UART_RX_FIFO_EN build setting.
module tb_uart_rx;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_if bus();

  uart_rx #(
    .clk_freq_hz (10_000_000),
    .baud_rate   (1_000_000),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_uart_rx (rx),
    .io_bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    cyc(DIV);
  endtask

  // Leaves the stop level on the line so a low stop can be extended into a break.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.o_valid && n < budget) begin
      cyc(1);
      n++;
    end
    check({tag, "_wait"}, 8'(bus.o_valid), 8'd1);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_vld"}, 8'(bus.o_valid), 8'd1);
    check({tag, "_dat"}, bus.o_data, exp);
    bus.i_ready = 1'b1;
    cyc(1);
    bus.i_ready = 1'b0;
  endtask

  task automatic clear_errors();
    bus.i_clr_err = 1'b1;
    cyc(1);
    bus.i_clr_err = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_ready   = 1'b0;
    bus.i_clr_err = 1'b0;
    cyc(3);
    check("rst_data",  bus.o_data, 8'h00);
    check("rst_valid", 8'(bus.o_valid), 8'd0);
    check("rst_ferr",  8'(bus.o_frame_err), 8'd0);
    check("rst_ovr",   8'(bus.o_overrun), 8'd0);
    rst = 1'b0;
    cyc(5);

    // 1: single frame, exact latency, stable data, pop
    fork
      send_frame(8'h55, 1'b1);
      begin
        cyc(97);
        check("t1_early", 8'(bus.o_valid), 8'd0);
        cyc(1);
        check("t1_valid", 8'(bus.o_valid), 8'd1);
        check("t1_data",  bus.o_data, 8'h55);
      end
    join
    cyc(5);
    check("t1_stable", bus.o_data, 8'h55);
    bus.i_ready = 1'b1;
    cyc(1);
    bus.i_ready = 1'b0;
    check("t1_popped", 8'(bus.o_valid), 8'd0);
    check("t1_ferr",   8'(bus.o_frame_err), 8'd0);

    // 2: glitch rejection
    rx = 1'b0;
    cyc(3);
    rx = 1'b1;
    cyc(30);
    check("t2_glitch_vld",  8'(bus.o_valid), 8'd0);
    check("t2_glitch_ferr", 8'(bus.o_frame_err), 8'd0);
    send_frame(8'hA3, 1'b1);
    wait_valid("t2", 20);
    pop_expect("t2", 8'hA3);

    // 3: framing error then break held low
    send_frame(8'h3C, 1'b0);
    cyc(30);
    check("t3_ferr",    8'(bus.o_frame_err), 8'd1);
    check("t3_nopush",  8'(bus.o_valid), 8'd0);
    rx = 1'b1;
    cyc(20);
    send_frame(8'h81, 1'b1);
    wait_valid("t3", 20);
    pop_expect("t3", 8'h81);
    check("t3_sticky",  8'(bus.o_frame_err), 8'd1);
    clear_errors();
    check("t3_clr",     8'(bus.o_frame_err), 8'd0);

    // 4: overrun
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    cyc(3);
    check("t4_no_ovr", 8'(bus.o_overrun), 8'd0);
    send_frame(8'h05, 1'b1);
    cyc(3);
    check("t4_ovr", 8'(bus.o_overrun), 8'd1);
    for (int i = 1; i <= 4; i++) pop_expect("t4_pop", 8'(i));
`else
    send_frame(8'h01, 1'b1);
    cyc(3);
    check("t4_no_ovr", 8'(bus.o_overrun), 8'd0);
    send_frame(8'h02, 1'b1);
    cyc(3);
    check("t4_ovr", 8'(bus.o_overrun), 8'd1);
    pop_expect("t4_pop", 8'h01);
`endif
    check("t4_empty", 8'(bus.o_valid), 8'd0);
    clear_errors();
    check("t4_clr", 8'(bus.o_overrun), 8'd0);

    // 5: full buffer, pop coincides with the stop-bit sample
`ifdef UART_RX_FIFO_EN
    for (int i = 2; i <= 5; i++) send_frame(8'(i), 1'b1);
`else
    send_frame(8'h05, 1'b1);
`endif
    cyc(3);
    check("t5_full_vld", 8'(bus.o_valid), 8'd1);
    fork
      send_frame(8'h06, 1'b1);
      begin
        cyc(97);
        bus.i_ready = 1'b1;
        cyc(1);
        bus.i_ready = 1'b0;
      end
    join
    cyc(3);
    check("t5_no_ovr", 8'(bus.o_overrun), 8'd0);
`ifdef UART_RX_FIFO_EN
    for (int i = 3; i <= 6; i++) pop_expect("t5_pop", 8'(i));
`else
    pop_expect("t5_pop", 8'h06);
`endif
    check("t5_empty", 8'(bus.o_valid), 8'd0);

    // 6: reset in the middle of a frame
    send_frame(8'h3C, 1'b0);
    cyc(5);
    rx = 1'b1;
    cyc(20);
    send_frame(8'h5A, 1'b1);
    cyc(3);
    check("t6_pre_vld",  8'(bus.o_valid), 8'd1);
    check("t6_pre_ferr", 8'(bus.o_frame_err), 8'd1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        cyc(55);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("t6_rst_data", bus.o_data, 8'h00);
        check("t6_rst_vld",  8'(bus.o_valid), 8'd0);
        check("t6_rst_ferr", 8'(bus.o_frame_err), 8'd0);
        check("t6_rst_ovr",  8'(bus.o_overrun), 8'd0);
      end
    join
    cyc(10);
    check("t6_abandoned", 8'(bus.o_valid), 8'd0);
    send_frame(8'h00, 1'b1);
    wait_valid("t6", 20);
    pop_expect("t6", 8'h00);
    check("t6_ferr", 8'(bus.o_frame_err), 8'd0);

    cyc(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
